hs_serializer: RTL and testbench

Parametrised parallel-to-serial transmitter for the high-speed link datapath. It accepts words of configurable width through a valid/ready handshake and buffers one word in a holding register. It shifts each word out one bit per `shift_enable` strobe, MSB- or LSB-first. Consecutive words stream with no idle bit between them, and a per-word completion pulse is produced.

---
 rtl/hs_serializer.sv | 105 ++++++++++
 tb/tb_hs_serializer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/hs_serializer.sv
// hs_serializer: parallel-to-serial transmitter with a one-word holding
// register. Words stream back-to-back with no idle bit between them, and
// word_done pulses once per completed word.
module hs_serializer #(
    parameter int   DATA_W    = 10,
    parameter int   MSB_FIRST = 1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_n_rst,        // active-high, asynchronous
    input  logic              i_in_valid,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_in_ready,
    input  logic              i_shift_enable,
    output logic              o_serial_out,
    output logic              o_word_done,
    output logic              o_busy
);

    localparam int            CW   = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            r_state, w_state_nxt;
    logic [DATA_W-1:0] r_hold_data;
    logic              r_hold_full;
    logic [DATA_W-1:0] r_sr;
    logic [DATA_W-1:0] w_sr_shifted;
    logic [CW-1:0]     r_bit_cnt;
    logic              r_word_done;
    logic              w_accept;
    logic              w_strobe;
    logic              w_last;
    logic              w_load;

    // Handshake, strobe qualification and hold->sr transfer decode
    always_comb begin
        w_accept = i_in_valid & o_in_ready;
        w_strobe = (r_state == SHIFT) & i_shift_enable;
        w_last   = w_strobe & (r_bit_cnt == LAST);
        // Transfer from IDLE, or gaplessly on the last bit's consuming edge
        w_load   = r_hold_full & ((r_state == IDLE) | w_last);
        // Shift toward the output end, zero-filling the vacated end
        if (MSB_FIRST != 0) w_sr_shifted = {r_sr[DATA_W-2:0], 1'b0};
        else                w_sr_shifted = {1'b0, r_sr[DATA_W-1:1]};
    end

    // FSM state register
    always_ff @(posedge i_clk or posedge i_n_rst) begin
        if (i_n_rst) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    // FSM next-state: leave IDLE when a word is held, return after the
    // last bit only if nothing is waiting in the hold
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (r_hold_full)              w_state_nxt = SHIFT;
            SHIFT:   if (w_last && !r_hold_full)   w_state_nxt = IDLE;
            default:                               w_state_nxt = IDLE;
        endcase
    end

    // Holding register: accepts only when empty, so never collides with a load
    always_ff @(posedge i_clk or posedge i_n_rst) begin
        if (i_n_rst) begin
            r_hold_data <= '0;
            r_hold_full <= 1'b0;
        end else if (w_accept) begin
            r_hold_data <= i_in_data;
            r_hold_full <= 1'b1;
        end else if (w_load) begin
            r_hold_full <= 1'b0;
        end
    end

    // Shift register and bit counter; everything holds while the strobe is low
    always_ff @(posedge i_clk or posedge i_n_rst) begin
        if (i_n_rst) begin
            r_sr      <= '0;
            r_bit_cnt <= '0;
        end else if (w_load) begin
            r_sr      <= r_hold_data;
            r_bit_cnt <= '0;
        end else if (w_strobe && !w_last) begin
            r_sr      <= w_sr_shifted;
            r_bit_cnt <= r_bit_cnt + CW'(1);
        end
    end

    // Completion pulse registered off the last bit's consuming edge
    always_ff @(posedge i_clk or posedge i_n_rst) begin
        if (i_n_rst) r_word_done <= 1'b0;
        else         r_word_done <= w_last;
    end

    assign o_in_ready   = ~r_hold_full & ~i_n_rst;
    assign o_serial_out = (r_state == SHIFT) ?
                          ((MSB_FIRST != 0) ? r_sr[DATA_W-1] : r_sr[0]) : IDLE_BIT;
    assign o_word_done  = r_word_done;
    assign o_busy       = (r_state == SHIFT) | r_hold_full;

endmodule

// File: tb/tb_hs_serializer.sv
// Directed bench for hs_serializer: one MSB-first instance and one
// LSB-first instance, inputs driven and outputs checked on the falling edge.
module tb_hs_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       se;
    logic       m_valid, l_valid;
    logic [9:0] m_data,  l_data;
    logic       m_ready, m_ser, m_done, m_busy;
    logic       l_ready, l_ser, l_done, l_busy;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    hs_serializer #(.DATA_W(10), .MSB_FIRST(1), .IDLE_BIT(1'b0)) dut (
        .i_clk(clk), .i_n_rst(rst), .i_in_valid(m_valid), .i_in_data(m_data),
        .o_in_ready(m_ready), .i_shift_enable(se), .o_serial_out(m_ser),
        .o_word_done(m_done), .o_busy(m_busy)
    );

    hs_serializer #(.DATA_W(10), .MSB_FIRST(0), .IDLE_BIT(1'b0)) dut_l (
        .i_clk(clk), .i_n_rst(rst), .i_in_valid(l_valid), .i_in_data(l_data),
        .o_in_ready(l_ready), .i_shift_enable(se), .o_serial_out(l_ser),
        .o_word_done(l_done), .o_busy(l_busy)
    );

    task automatic chk(input string tag, input logic got, input logic exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    initial begin
        logic [9:0] w, wa, wb, wc;

        // ---- reset state
        rst = 1'b1; se = 1'b0;
        m_valid = 1'b0; m_data = '0; l_valid = 1'b0; l_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", m_ready, 1'b0);
        chk("rst_ser",   m_ser,   1'b0);
        chk("rst_busy",  m_busy,  1'b0);
        chk("rst_done",  m_done,  1'b0);
        rst = 1'b0;
        #1 chk("rel_ready", m_ready, 1'b1);

        // ---- single word 10'h2C5, MSB first, strobe tied high
        w = 10'b10_1100_0101;
        m_valid = 1'b1; m_data = 10'h2C5; se = 1'b1;
        @(negedge clk);
        m_valid = 1'b0;
        chk("t1_busy_hold", m_busy, 1'b1);
        chk("t1_ready_hold", m_ready, 1'b0);
        chk("t1_ser_idle", m_ser, 1'b0);
        for (int i = 9; i >= 0; i--) begin
            @(negedge clk);
            chk("t1_bit", m_ser, w[i]);
            chk("t1_done_lo", m_done, 1'b0);
            chk("t1_busy", m_busy, 1'b1);
            if (i == 9) chk("t1_ready_back", m_ready, 1'b1);
        end
        @(negedge clk);
        chk("t1_done_hi", m_done, 1'b1);
        chk("t1_ser_idle_end", m_ser, 1'b0);
        chk("t1_busy_fall", m_busy, 1'b0);
        @(negedge clk);
        chk("t1_done_once", m_done, 1'b0);

        // ---- back-to-back 3FF then 000 with valid held high
        m_valid = 1'b1; m_data = 10'h3FF;
        @(negedge clk);
        chk("t2_ready_hold1", m_ready, 1'b0);
        for (int i = 9; i >= 0; i--) begin
            @(negedge clk);
            chk("t2_ones", m_ser, 1'b1);
            if (i == 9) begin
                chk("t2_ready_first", m_ready, 1'b1);
                m_data = 10'h000;
            end else begin
                m_valid = 1'b0;
                chk("t2_ready_wait", m_ready, 1'b0);
            end
        end
        for (int i = 9; i >= 0; i--) begin
            @(negedge clk);
            chk("t2_zeros", m_ser, 1'b0);
            chk("t2_busy", m_busy, 1'b1);
            chk("t2_done", m_done, (i == 9));
        end
        @(negedge clk);
        chk("t2_done2", m_done, 1'b1);
        chk("t2_busy_end", m_busy, 1'b0);

        // ---- LSB-first instance, 10'h001
        l_valid = 1'b1; l_data = 10'h001;
        @(negedge clk);
        l_valid = 1'b0;
        chk("t3_busy", l_busy, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t3_lsb_bit", l_ser, (i == 0));
        end
        @(negedge clk);
        chk("t3_done", l_done, 1'b1);
        chk("t3_ready", l_ready, 1'b1);

        // ---- strobe every third cycle, 10'h155
        w = 10'b01_0101_0101;
        se = 1'b0; m_valid = 1'b1; m_data = 10'h155;
        @(negedge clk);
        m_valid = 1'b0;
        for (int i = 9; i >= 0; i--) begin
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                chk("t4_bit", m_ser, w[i]);
                chk("t4_done_lo", m_done, 1'b0);
                se = (c == 2);
            end
        end
        @(negedge clk);
        se = 1'b0;
        chk("t4_done", m_done, 1'b1);
        chk("t4_idle", m_ser, 1'b0);
        @(negedge clk);
        chk("t4_done_once", m_done, 1'b0);

        // ---- backpressure: three words, third stalls while the hold is full
        wa = 10'h2A7; wb = 10'h1C3; wc = 10'h35A;
        se = 1'b1; m_valid = 1'b1; m_data = wa;
        @(negedge clk);
        chk("t5_ready_a", m_ready, 1'b0);
        m_data = wb;
        for (int i = 9; i >= 0; i--) begin
            @(negedge clk);
            chk("t5_a_bit", m_ser, wa[i]);
            if (i == 9) chk("t5_ready_b", m_ready, 1'b1);
            else        chk("t5_stall_c", m_ready, 1'b0);
            if (i == 8) m_data = wc;
        end
        for (int i = 9; i >= 0; i--) begin
            @(negedge clk);
            chk("t5_b_bit", m_ser, wb[i]);
            if (i == 9) begin
                chk("t5_done_a", m_done, 1'b1);
                chk("t5_ready_c", m_ready, 1'b1);
            end
            if (i == 8) begin
                chk("t5_ready_cheld", m_ready, 1'b0);
                m_valid = 1'b0;
            end
        end
        for (int i = 9; i >= 0; i--) begin
            @(negedge clk);
            chk("t5_c_bit", m_ser, wc[i]);
            if (i == 9) chk("t5_done_b", m_done, 1'b1);
        end
        @(negedge clk);
        chk("t5_done_c", m_done, 1'b1);
        chk("t5_busy_end", m_busy, 1'b0);

        // ---- reset mid-word with a second word held
        wa = 10'h3C5;
        m_valid = 1'b1; m_data = wa;
        @(negedge clk);
        m_data = 10'h0F0;
        for (int i = 9; i >= 6; i--) begin
            @(negedge clk);
            chk("t6_bit", m_ser, wa[i]);
            if (i == 8) m_valid = 1'b0;
        end
        chk("t6_held", m_ready, 1'b0);
        rst = 1'b1;
        #1;
        chk("t6_ser_rst", m_ser, 1'b0);
        chk("t6_ready_rst", m_ready, 1'b0);
        chk("t6_busy_rst", m_busy, 1'b0);
        repeat (2) begin
            @(negedge clk);
            chk("t6_no_done", m_done, 1'b0);
            chk("t6_ready_in_rst", m_ready, 1'b0);
        end
        rst = 1'b0;
        #1 chk("t6_ready_rel", m_ready, 1'b1);
        chk("t6_busy_rel", m_busy, 1'b0);
        wb = 10'h0B3;
        m_valid = 1'b1; m_data = wb;
        @(negedge clk);
        m_valid = 1'b0;
        for (int i = 9; i >= 0; i--) begin
            @(negedge clk);
            chk("t6_fresh_bit", m_ser, wb[i]);
            chk("t6_fresh_done_lo", m_done, 1'b0);
        end
        @(negedge clk);
        chk("t6_fresh_done", m_done, 1'b1);
        chk("t6_fresh_busy", m_busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
